dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: port 0 is the processor datapath load/store path (cpu_*), port 1 is the board I/O / debug loader (dbg_*).
- It sits between the DataPath memory interface and the data-memory BRAM.
- It uses round-robin arbitration, a three-state sequencer and a req/ack handshake.
- It absorbs the synchronous-read latency of the BRAM and rejects out-of-range addresses without touching memory.

Parameters:
- AW, 10, word-address width on both requester ports and on the memory port.
- DW, 32, data width.
- DEPTH, 1024, number of implemented words; an address >= DEPTH is out of range.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU request; level, held until cpu_ack.
- cpu_we  input  1  1 = store, 0 = load; stable while cpu_req is high.
- cpu_addr  input  AW  word address; stable while cpu_req is high.
- cpu_wdata  input  DW  store data; stable while cpu_req is high.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DW  load data; valid only in the cpu_ack cycle.
- cpu_err  output  1  out-of-range flag; valid only in the cpu_ack cycle.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, dbg_err: same as the cpu_* group, for the debug port.
- mem_en  output  1  BRAM enable.
- mem_we  output  1  BRAM write enable.
- mem_addr  output  AW  BRAM address.
- mem_wdata  output  DW  BRAM write data.
- mem_rdata  input  DW  BRAM read data; valid one cycle after an enabled read.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port not granted last (last_grant register).
  - On a grant: latch winner id, we, addr and wdata into internal registers; set range_ok = (addr < DEPTH); go to ISSUE.
  - last_grant updates at that same edge.
- ISSUE (one cycle):
  - mem_en = range_ok, mem_we = latched_we & range_ok.
  - mem_addr and mem_wdata are driven from the latched registers.
  - Next state is RESP.
- RESP (one cycle):
  - Assert the winner's ack for exactly one cycle.
  - rdata = mem_rdata if latched_we == 0 and range_ok; otherwise rdata = 0.
  - err = ~range_ok.
  - Next state is IDLE.
- Latency: req seen in IDLE at cycle t gives mem_en at t+1 and ack at t+2. One transaction every 3 cycles at most.
- Handshake:
  - The requester must hold req, we, addr and wdata stable until ack.
  - In the cycle after ack, req must be low, or high only for a new transaction.
  - The arbiter never samples req outside IDLE.
  - A req dropped before ack is a protocol violation; behaviour is undefined.
- Loser port: keeps waiting. It is guaranteed the next grant, so worst-case wait is one full transaction (3 cycles) plus its own 3.
- Outputs not being acked: ack, rdata and err are 0.
- Outside ISSUE: mem_en = 0, mem_we = 0. mem_addr and mem_wdata hold the latched values; they are don't-care to the BRAM.
- Out-of-range stores: no write occurs. Out-of-range loads return 0. In both cases err = 1.
- busy = 1 in ISSUE and RESP.
- Reset (asynchronous, any state, including mid-transaction):
  - Go to IDLE.
  - All ack, err and rdata outputs = 0; mem_en = 0, mem_we = 0; mem_addr = 0, mem_wdata = 0; busy = 0.
  - last_grant = 1, so CPU wins the first tie.
  - Latched registers = 0.
  - An interrupted store is either not performed or completed in the BRAM. Neither is acknowledged, and the requester must re-issue it after reset.
- Widths: no arithmetic beyond the range compare. The compare is unsigned, at AW bits.

Test Plan:
- Reset, then cpu store addr 5 data 0xDEADBEEF, then cpu load addr 5: mem_en high 1 cycle after each req; cpu_ack 2 cycles after req; load returns cpu_rdata = 0xDEADBEEF, cpu_err = 0.
- cpu_req and dbg_req rise together, 3 times back-to-back: grants go CPU, DBG, CPU, DBG…, acks spaced 3 cycles apart; neither port waits more than 6 cycles.
- dbg store addr 1023 data 0x12345678, then cpu load addr 1023: cpu_rdata = 0x12345678, and dbg_ack precedes cpu_ack.
- DEPTH = 512, cpu store addr 600: mem_en never asserted, cpu_ack with cpu_err = 1. A later load of addr 600 gives cpu_rdata = 0, cpu_err = 1.
- Assert rst during ISSUE of a dbg load: all outputs 0 immediately, before the clock; no dbg_ack. After release, a simultaneous cpu/dbg request grants CPU first.
- Only dbg_req active for 10 transactions, cpu_req idle: every dbg request served every 3 cycles; cpu_ack stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous-read data BRAM.
// Port 0 is the CPU load/store path, port 1 the debug loader. Each transaction takes
// exactly three cycles: IDLE (grant and latch), ISSUE (drive the BRAM), RESP (ack).
module dmem_arbiter #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_err,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    // When DEPTH covers the whole address space every address is in range; otherwise the
    // limit fits in AW bits and a plain unsigned compare is enough.
    localparam bit            AllInRange = (DEPTH >= (32'd1 << AW));
    localparam logic [AW-1:0] DepthLim   = AW'(DEPTH);

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;  // 0 = cpu, 1 = dbg
    logic          winner_q, winner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          range_ok_q, range_ok_d;

    logic          grant_dbg;
    logic [AW-1:0] sel_addr;
    logic          sel_in_range;
    logic [DW-1:0] resp_data;

    // Debug wins when it is the only requester, or on a tie when the CPU was served last.
    assign grant_dbg    = dbg_req & (~cpu_req | ~last_grant_q);
    assign sel_addr     = grant_dbg ? dbg_addr : cpu_addr;
    assign sel_in_range = AllInRange || (sel_addr < DepthLim);
    assign resp_data    = (!we_q && range_ok_q) ? mem_rdata : '0;

    // State and latched-transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            range_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            range_ok_q   <= range_ok_d;
        end
    end

    // Sequencer: requests are only looked at in IDLE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        range_ok_d   = range_ok_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req || dbg_req) begin
                    winner_d     = grant_dbg;
                    last_grant_d = grant_dbg;
                    we_d         = grant_dbg ? dbg_we : cpu_we;
                    addr_d       = sel_addr;
                    wdata_d      = grant_dbg ? dbg_wdata : cpu_wdata;
                    range_ok_d   = sel_in_range;
                    state_d      = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; the BRAM read data is valid in RESP.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = 1'b0;
        cpu_rdata = '0;
        cpu_err   = 1'b0;
        dbg_ack   = 1'b0;
        dbg_rdata = '0;
        dbg_err   = 1'b0;
        busy      = (state_q != StIdle);
        if (state_q == StIssue) begin
            mem_en = range_ok_q;
            mem_we = we_q & range_ok_q;
        end
        if (state_q == StResp) begin
            if (winner_q) begin
                dbg_ack   = 1'b1;
                dbg_rdata = resp_data;
                dbg_err   = ~range_ok_q;
            end else begin
                cpu_ack   = 1'b1;
                cpu_rdata = resp_data;
                cpu_err   = ~range_ok_q;
            end
        end
    end

endmodule
